// File: rtl/rv_fetch_pkg.sv
// Shared fetch-path definitions: data widths, boot address, PC step and the
// buffered instruction entry layout.
package rv_fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0100_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Clear the byte offset so the result is a word address.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle around the fetch unit: instruction-memory request/response
// channel and the decode-side instruction channel.
//   master: the fetch unit (drives requests and the decode channel)
//   slave : the environment (memory and decode)
interface instr_fetch_unit_if;
    import rv_fetch_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               if_valid;
    logic               if_ready;
    logic [XLEN-1:0]    if_pc;
    logic [INSTR_W-1:0] if_instr;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output if_valid, if_pc, if_instr,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_pc, if_instr,
        output if_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush, used as the fetched-instruction
// buffer. Head is read straight from storage (no bypass), so a push becomes
// visible the cycle after it is written.
// Ports:
//   clk, rst         clock, async active-low reset
//   flush            empties the FIFO; overrides push/pop that cycle
//   push, push_data  write one entry
//   pop              retire the head entry
//   head             current head entry
//   empty, count     occupancy status
module fetch_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = rv_fetch_pkg::fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    always_comb begin
        do_pop  = pop & (count != '0);
        do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues word requests to
// instruction memory, buffers in-order responses with their PCs and hands
// them to decode. Redirects flush the buffer and arrange for responses still
// in flight to be discarded.
// Ports:
//   clk, rst             clock, async active-low reset
//   fetch_en             allows new requests (responses/drain continue when 0)
//   redirect_valid/pc    one-cycle control-flow redirect
//   misaligned_redirect  one-cycle pulse after a redirect with pc[1:0] != 0
//   bus                  memory request/response and decode channels
module instr_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                misaligned_redirect,
    instr_fetch_unit_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  rsp_pc;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] drop;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;

    logic [SUM_W-1:0] space_used_c;
    logic             req_valid_c;
    logic             req_fire_c;
    logic             rsp_push_c;
    logic             pop_c;
    logic [OUT_W-1:0] out_next_c;
    logic [OUT_W-1:0] drop_next_c;

    // Request gating, response routing and counter next-state.
    // Buffer slots are reserved for every live (non-dropped) outstanding
    // request, so a response can always be pushed.
    always_comb begin
        space_used_c = SUM_W'(fifo_count) + SUM_W'(outstanding) - SUM_W'(drop);
        req_valid_c  = rst & fetch_en & ~redirect_valid
                     & (outstanding < OUT_W'(MAX_OUTSTANDING))
                     & (space_used_c < SUM_W'(FIFO_DEPTH));
        req_fire_c   = req_valid_c & bus.imem_req_ready;
        rsp_push_c   = bus.imem_rsp_valid & (drop == '0) & ~redirect_valid;
        pop_c        = ~fifo_empty & bus.if_ready & ~redirect_valid;
        out_next_c   = outstanding + OUT_W'(req_fire_c) - OUT_W'(bus.imem_rsp_valid);

        drop_next_c = drop;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            drop_next_c = out_next_c;
        end else if (bus.imem_rsp_valid && (drop != '0)) begin
            drop_next_c = drop - OUT_W'(1);
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc            <= RESET_PC;
            rsp_pc              <= RESET_PC;
            outstanding         <= '0;
            drop                <= '0;
            misaligned_redirect <= 1'b0;
        end else begin
            outstanding         <= out_next_c;
            drop                <= drop_next_c;
            misaligned_redirect <= redirect_valid & (|redirect_pc[1:0]);
            if (redirect_valid) begin
                fetch_pc <= align_word(redirect_pc);
                rsp_pc   <= align_word(redirect_pc);
            end else begin
                if (req_fire_c) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (rsp_push_c) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                end
            end
        end
    end

    assign push_entry = '{pc: rsp_pc, instr: bus.imem_rsp_data};

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_push_c),
        .push_data (push_entry),
        .pop       (pop_c),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.if_valid       = ~fifo_empty;
    assign bus.if_pc          = fifo_head.pc;
    assign bus.if_instr       = fifo_head.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit. A small in-order memory model
// answers accepted requests one cycle later with data = addr + 0x10000000.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misaligned_redirect;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC        (32'h0100_0000),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .fetch_en            (fetch_en),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .misaligned_redirect (misaligned_redirect),
        .bus                 (bus)
    );

    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] pend[$];
    logic        rsp_en;
    int          n_req;
    logic [31:0] last_req_addr;

    // One clock: record a handshake, advance, then drive any due response.
    task automatic cycle();
        #1;
        if (rst && bus.imem_req_valid && bus.imem_req_ready) begin
            pend.push_back(bus.imem_req_addr);
            n_req++;
            last_req_addr = bus.imem_req_addr;
        end
        @(posedge clk);
        #1;
        if (rst && rsp_en && pend.size() > 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = pend.pop_front() + 32'h1000_0000;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst                = 1'b0;
        fetch_en           = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        bus.if_ready       = 1'b0;
        bus.imem_req_ready = 1'b1;
        rsp_en             = 1'b1;
        pend.delete();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        repeat (2) cycle();
        rst   = 1'b1;
        n_req = 0;
    endtask

    task automatic test_reset();
        rst                = 1'b0;
        fetch_en           = 1'b1;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        bus.if_ready       = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        rsp_en             = 1'b1;
        repeat (2) cycle();
        #1;
        tests_run++;
        if (bus.if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_if_valid: got %b expected 0", bus.if_valid); end
        tests_run++;
        if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
        tests_run++;
        if (misaligned_redirect !== 1'b0) begin tests_failed++; $display("FAIL reset_misaligned: got %b expected 0", misaligned_redirect); end
        tests_run++;
        if (bus.if_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_if_pc: got %h expected 00000000", bus.if_pc); end
        tests_run++;
        if (bus.if_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_if_instr: got %h expected 00000000", bus.if_instr); end
        tests_run++;
        if (bus.imem_req_addr !== 32'h0100_0000) begin tests_failed++; $display("FAIL reset_req_addr: got %h expected 01000000", bus.imem_req_addr); end
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL reset_first_req: got %b expected 1", bus.imem_req_valid); end
    endtask

    task automatic test_stream();
        do_reset();
        fetch_en     = 1'b1;
        bus.if_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.imem_req_addr !== 32'h0100_0000 || bus.imem_req_valid !== 1'b1) begin
            tests_failed++; $display("FAIL stream_req0: got v=%b a=%h expected v=1 a=01000000", bus.imem_req_valid, bus.imem_req_addr);
        end
        cycle(); #1;
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.imem_req_addr !== 32'h0100_0004) begin
            tests_failed++; $display("FAIL stream_c1: got if_valid=%b a=%h expected 0 01000004", bus.if_valid, bus.imem_req_addr);
        end
        cycle(); #1;
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0100_0000 || bus.if_instr !== 32'h1100_0000) begin
            tests_failed++; $display("FAIL stream_out0: got v=%b pc=%h i=%h expected 1 01000000 11000000", bus.if_valid, bus.if_pc, bus.if_instr);
        end
        tests_run++;
        if (bus.imem_req_addr !== 32'h0100_0008) begin tests_failed++; $display("FAIL stream_req2: got %h expected 01000008", bus.imem_req_addr); end
        cycle(); #1;
        tests_run++;
        if (bus.if_pc !== 32'h0100_0004 || bus.if_instr !== 32'h1100_0004) begin
            tests_failed++; $display("FAIL stream_out1: got pc=%h i=%h expected 01000004 11000004", bus.if_pc, bus.if_instr);
        end
        cycle(); #1;
        tests_run++;
        if (bus.if_pc !== 32'h0100_0008 || bus.if_instr !== 32'h1100_0008) begin
            tests_failed++; $display("FAIL stream_out2: got pc=%h i=%h expected 01000008 11000008", bus.if_pc, bus.if_instr);
        end
    endtask

    task automatic test_decode_stall();
        do_reset();
        fetch_en = 1'b1;
        repeat (10) cycle();
        #1;
        tests_run++;
        if (n_req !== 4) begin tests_failed++; $display("FAIL stall_req_count: got %0d expected 4", n_req); end
        tests_run++;
        if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_req_valid: got %b expected 0", bus.imem_req_valid); end
        tests_run++;
        if (bus.if_pc !== 32'h0100_0000) begin tests_failed++; $display("FAIL stall_head: got %h expected 01000000", bus.if_pc); end
        n_req        = 0;
        bus.if_ready = 1'b1;
        cycle();
        bus.if_ready = 1'b0;
        repeat (8) cycle();
        #1;
        tests_run++;
        if (n_req !== 1) begin tests_failed++; $display("FAIL stall_one_more: got %0d expected 1", n_req); end
        tests_run++;
        if (last_req_addr !== 32'h0100_0010) begin tests_failed++; $display("FAIL stall_more_addr: got %h expected 01000010", last_req_addr); end
        tests_run++;
        if (bus.if_pc !== 32'h0100_0004) begin tests_failed++; $display("FAIL stall_head2: got %h expected 01000004", bus.if_pc); end
    endtask

    // Leaves one entry buffered, two requests outstanding, responses held.
    task automatic setup_two_outstanding();
        do_reset();
        fetch_en = 1'b1;
        cycle();
        rsp_en = 1'b0;
        cycle();
        cycle();
        #1;
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.imem_req_valid !== 1'b0 || n_req !== 3) begin
            tests_failed++; $display("FAIL setup_state: got if_valid=%b req_valid=%b n_req=%0d expected 1 0 3", bus.if_valid, bus.imem_req_valid, n_req);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] first_addr;
        bit          got_first;
        first_addr = '0;
        got_first  = 1'b0;
        setup_two_outstanding();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0100;
        rsp_en         = 1'b1;
        #1;
        tests_run++;
        if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_no_req: got %b expected 0", bus.imem_req_valid); end
        cycle();
        redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.if_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_flush: got %b expected 0", bus.if_valid); end
        tests_run++;
        if (bus.imem_req_addr !== 32'h0100_0100) begin tests_failed++; $display("FAIL redir_addr: got %h expected 01000100", bus.imem_req_addr); end
        n_req = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (n_req >= 1 && !got_first) begin first_addr = last_req_addr; got_first = 1'b1; end
            if (bus.if_valid) break;
        end
        #1;
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0100_0100 || bus.if_instr !== 32'h1100_0100) begin
            tests_failed++; $display("FAIL redir_first_out: got v=%b pc=%h i=%h expected 1 01000100 11000100", bus.if_valid, bus.if_pc, bus.if_instr);
        end
        tests_run++;
        if (first_addr !== 32'h0100_0100) begin tests_failed++; $display("FAIL redir_first_req: got %h expected 01000100", first_addr); end
        bus.if_ready = 1'b1;
        cycle();
        bus.if_ready = 1'b0;
        #1;
        tests_run++;
        if (bus.if_pc !== 32'h0100_0104) begin tests_failed++; $display("FAIL redir_second_out: got %h expected 01000104", bus.if_pc); end
    endtask

    task automatic test_back_to_back();
        setup_two_outstanding();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0300;
        rsp_en         = 1'b1;
        cycle();
        redirect_pc = 32'h0100_0200;
        cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus.if_valid) break;
        end
        #1;
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0100_0200 || bus.if_instr !== 32'h1100_0200) begin
            tests_failed++; $display("FAIL b2b_first_out: got v=%b pc=%h i=%h expected 1 01000200 11000200", bus.if_valid, bus.if_pc, bus.if_instr);
        end
    endtask

    task automatic test_misaligned();
        int pulses;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0102;
        #1;
        tests_run++;
        if (misaligned_redirect !== 1'b0) begin tests_failed++; $display("FAIL mis_early: got %b expected 0", misaligned_redirect); end
        cycle();
        redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (misaligned_redirect !== 1'b1) begin tests_failed++; $display("FAIL mis_pulse: got %b expected 1", misaligned_redirect); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(); #1;
            if (misaligned_redirect) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin tests_failed++; $display("FAIL mis_single: got %0d extra pulses expected 0", pulses); end
        fetch_en = 1'b1;
        #1;
        tests_run++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0100_0100) begin
            tests_failed++; $display("FAIL mis_resume: got v=%b a=%h expected 1 01000100", bus.imem_req_valid, bus.imem_req_addr);
        end
        fetch_en       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0200;
        cycle();
        redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (misaligned_redirect !== 1'b0) begin tests_failed++; $display("FAIL mis_aligned_quiet: got %b expected 0", misaligned_redirect); end
    endtask

    task automatic test_req_stall();
        do_reset();
        fetch_en           = 1'b1;
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0100_0000) begin
                tests_failed++; $display("FAIL req_hold_%0d: got v=%b a=%h expected 1 01000000", i, bus.imem_req_valid, bus.imem_req_addr);
            end
            cycle();
        end
        bus.imem_req_ready = 1'b1;
        cycle();
        bus.imem_req_ready = 1'b0;
        #1;
        tests_run++;
        if (bus.imem_req_addr !== 32'h0100_0004 || n_req !== 1) begin
            tests_failed++; $display("FAIL req_accept_step: got a=%h n=%0d expected 01000004 1", bus.imem_req_addr, n_req);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        fetch_en = 1'b1;
        repeat (4) cycle();
        #1;
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0100_0000) begin
            tests_failed++; $display("FAIL midrst_pre: got v=%b pc=%h expected 1 01000000", bus.if_valid, bus.if_pc);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_clear: got if_valid=%b req_valid=%b expected 0 0", bus.if_valid, bus.imem_req_valid);
        end
        pend.delete();
        bus.imem_rsp_valid = 1'b0;
        cycle();
        rst   = 1'b1;
        n_req = 0;
        #1;
        tests_run++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0100_0000) begin
            tests_failed++; $display("FAIL midrst_restart: got v=%b a=%h expected 1 01000000", bus.imem_req_valid, bus.imem_req_addr);
        end
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus.if_valid) break;
        end
        #1;
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0100_0000) begin
            tests_failed++; $display("FAIL midrst_first_out: got v=%b pc=%h expected 1 01000000", bus.if_valid, bus.if_pc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_decode_stall();
        test_redirect();
        test_back_to_back();
        test_misaligned();
        test_req_stall();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
